av_io_target: RTL

Generic device-side responder for the AV I/O bridge's master port. It decodes a bridge cycle qualified by the device's chip-select, inserts a programmable number of wait states, and reads or writes a small bank of byte-lane-writable 32-bit registers. It then holds acknowledge until the bridge drops strobe. It is the endpoint template for low-speed AV peripherals: sound generator, codec control, and the like.

---
 rtl/av_io_target.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/av_io_target.sv
// ---------------------------------------------------------------------------
// AvIoTarget: generic device-side responder for the AV I/O bridge master port.
//
// It accepts a bridge cycle qualified by chip-select, inserts WAIT_STATES
// wait cycles, and then reads or writes one of NREG byte-lane-writable
// 32-bit registers. Acknowledge is held until the bridge drops strobe.
//
// Ports:
//   clk_i    - bus clock (single domain)
//   rst_i    - synchronous, active-high reset
//   cs_i     - device chip-select
//   cyc_i    - bus cycle active
//   stb_i    - strobe
//   ack_o    - transfer acknowledge (registered)
//   stall_o  - busy, high in WAIT and ACK (registered)
//   we_i     - write enable
//   sel_i    - byte-lane selects, bit n covers data bits 8n+7:8n
//   adr_i    - byte address, register index = adr_i[$clog2(NREG)+1:2]
//   dat_i    - write data
//   dat_o    - read data, zero unless a read is being acknowledged
//   regs_o   - flattened register contents, register k at bits 32k+31:32k
// ---------------------------------------------------------------------------
module av_io_target #(
   parameter int          WID         = 32,
   parameter int          NREG        = 8,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] RST_VAL     = 32'h0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cs_i,
   input  logic                cyc_i,
   input  logic                stb_i,
   output logic                ack_o,
   output logic                stall_o,
   input  logic                we_i,
   input  logic [3:0]          sel_i,
   input  logic [31:0]         adr_i,
   input  logic [WID-1:0]      dat_i,
   output logic [WID-1:0]      dat_o,
   output logic [NREG*WID-1:0] regs_o
);

   localparam int IW = $clog2(NREG);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } stateT;

   stateT           r_state;
   stateT           w_nextState;
   logic [3:0]      r_cnt;
   logic [3:0]      w_cntNext;
   logic            w_accept;
   logic            w_enterAck;

   logic            r_we;
   logic [3:0]      r_sel;
   logic [IW-1:0]   r_idx;
   logic [WID-1:0]  r_dat;

   logic            w_curWe;
   logic [3:0]      w_curSel;
   logic [IW-1:0]   w_curIdx;
   logic [WID-1:0]  w_curDat;
   logic [WID-1:0]  w_datNext;

   logic            r_ack;
   logic            r_stall;
   logic [WID-1:0]  r_datO;
   logic [WID-1:0]  r_regs [NREG];

   logic            w_req;
   logic            w_unusedAdr;

   assign w_req       = cs_i & cyc_i & stb_i;
   assign w_unusedAdr = ^{adr_i[31:IW+2], adr_i[1:0]};

   // With zero wait states ACK is entered on the accept edge itself, so the
   // transfer attributes come straight from the bus; otherwise from the
   // copies latched at accept time.
   assign w_curWe  = (r_state == IDLE) ? we_i             : r_we;
   assign w_curSel = (r_state == IDLE) ? sel_i            : r_sel;
   assign w_curIdx = (r_state == IDLE) ? adr_i[IW+1:2]    : r_idx;
   assign w_curDat = (r_state == IDLE) ? dat_i            : r_dat;

   // Next-state logic. In WAIT a dropped cyc_i is checked before the
   // counter so that an abort always wins over a simultaneous expiry.
   always_comb begin
      w_nextState = r_state;
      w_cntNext   = r_cnt;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               w_accept  = 1'b1;
               w_cntNext = 4'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  w_nextState = ACK;
               end else begin
                  w_nextState = WAIT;
               end
            end
         end
         WAIT: begin
            if (!cyc_i) begin
               w_nextState = IDLE;
            end else if (r_cnt == 4'd1) begin
               w_nextState = ACK;
            end else begin
               w_cntNext = r_cnt - 4'd1;
            end
         end
         ACK: begin
            if (!stb_i) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Writes and read captures happen only on the edge that enters ACK, so
   // a long-held ack never commits a write twice.
   assign w_enterAck = (w_nextState == ACK) && (r_state != ACK);

   always_comb begin
      w_datNext = '0;
      if (w_enterAck && !w_curWe) begin
         w_datNext = r_regs[w_curIdx];
      end else if ((r_state == ACK) && (w_nextState == ACK)) begin
         w_datNext = r_datO;
      end
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Registered outputs, latched request and register bank. Reset takes
   // priority, which also discards a write that was about to commit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt   <= '0;
         r_ack   <= 1'b0;
         r_stall <= 1'b0;
         r_datO  <= '0;
         r_we    <= 1'b0;
         r_sel   <= '0;
         r_idx   <= '0;
         r_dat   <= '0;
         for (int k = 0; k < NREG; k++) begin
            r_regs[k] <= RST_VAL;
         end
      end else begin
         r_cnt   <= w_cntNext;
         r_ack   <= (w_nextState == ACK);
         r_stall <= (w_nextState != IDLE);
         r_datO  <= w_datNext;
         if (w_accept) begin
            r_we  <= we_i;
            r_sel <= sel_i;
            r_idx <= adr_i[IW+1:2];
            r_dat <= dat_i;
         end
         if (w_enterAck && w_curWe) begin
            for (int b = 0; b < 4; b++) begin
               if (w_curSel[b]) begin
                  r_regs[w_curIdx][8*b +: 8] <= w_curDat[8*b +: 8];
               end
            end
         end
      end
   end

   assign ack_o   = r_ack;
   assign stall_o = r_stall;
   assign dat_o   = r_datO;

   for (genvar k = 0; k < NREG; k++) begin : g_regsOut
      assign regs_o[WID*k +: WID] = r_regs[k];
   end

endmodule
